gate_reduce: RTL and testbench
==============================

# gate_reduce

Parametrised, sequential successor to the fixed 3-input AND gate. It reduces a WIDTH-bit input word with a selectable logic operation: AND, OR, XOR, NAND, NOR or XNOR. It accumulates the result across a multi-beat frame under a valid/ready handshake and presents one registered result bit per frame. It sits between a streaming bit-vector source and any consumer needing a frame-wide logic predicate, such as all-ones, any-set or parity.

## Interface
- WIDTH, 3, bits per input beat; legal range 2..64
- CNT_W, 8, width of the beat counter
- clk  input  1  clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  beat offered
- in_ready  output  1  block can accept a beat
- in_data  input  WIDTH  beat payload
- in_last  input  1  beat is the final beat of the frame
- mode  input  3  operation; sampled on the first beat of a frame only
- out_valid  output  1  frame result available
- out_ready  input  1  consumer accepts the result
- out_z  output  1  frame result
- out_beats  output  CNT_W  beats in the frame; saturates at 2^CNT_W-1
- out_err  output  1  reserved mode was used for the frame
- in_mask  input  WIDTH  only present with GATE_REDUCE_MASK_EN; 1 means the bit participates

## Operation
- Mode encoding:
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR.
  - 6 and 7 are reserved.
- Base operation: AND for modes 0/3, OR for 1/4, XOR for 2/5.
- Inversion: modes 3–5 invert once, at the output, over the whole frame. For example, NAND is NOT(AND of every bit of every beat).
- Beat acceptance: a beat is accepted when in_valid && in_ready.
- FSM states are IDLE, ACCUM and DONE.
- IDLE (in_ready=1):
  - On accept, latch mode.
  - Load the accumulator with the base reduction of the beat, and set the count to 1.
  - Go to DONE if in_last, else to ACCUM.
- ACCUM (in_ready=1):
  - On accept, set acc = acc op reduce(beat) and increment the count, saturating.
  - Go to DONE if in_last.
- DONE (in_ready=0, out_valid=1):
  - out_z, out_beats and out_err are stable while out_valid && !out_ready.
  - On out_ready, go to IDLE.
- Reserved mode latched: the frame is still consumed normally. The result is out_z=0 and out_err=1.
- mode changes after the first beat are ignored until the next frame.
- in_data, in_last and mode are don't-care when in_valid=0.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, out_z=0, out_beats=0, out_err=0, accumulator cleared.
- Latency: out_valid rises on the cycle after the last beat is accepted; all outputs are registered.
- Throughput:
  - One beat per cycle inside a frame.
  - One bubble cycle per frame, because in_ready=0 in DONE.
  - A new frame's first beat is accepted earliest on the cycle after the result handshake.
- Outputs in non-DONE states: out_z, out_beats and out_err hold their last values but are meaningful only while out_valid=1.
- Reset mid-frame: the partial frame is discarded and no result is emitted. Reset while in DONE drops the pending result.
- Single-beat frame (first beat with in_last=1): IDLE→DONE directly, out_beats=1.
- Counter: saturates at 2^CNT_W-1 and does not wrap. The reduction stays correct past saturation.

## Configuration
- GATE_REDUCE_MASK_EN defined:
  - The in_mask port exists.
  - Masked-off bits are replaced by the identity of the base operation before reduction: 1 for AND, 0 for OR/XOR.
  - An all-zero mask beat leaves the accumulator unchanged but still counts as a beat.
- GATE_REDUCE_MASK_EN undefined: the port is absent and all WIDTH bits participate.

## Structure
- Package gate_reduce_pkg holds:
  - the mode enum (MODE_AND..MODE_XNOR, reserved values);
  - the base-operation enum;
  - the state enum (IDLE, ACCUM, DONE);
  - the identity-value function.
- Sub-module gate_reduce_beat: combinational single-beat reduction. Inputs are data, the base operation and the optional mask; the output is 1 bit. It is instantiated once.

## Test plan
- WIDTH=3, mode 0, eight single-beat frames 000..111 → out_z=1 only for 111; out_beats=1 every frame.
- Mode 3 (NAND), 3-beat frame 111,111,110 → out_z=1, out_beats=3. Same frame with all beats 111 → out_z=0.
- Mode 2 (XOR), frame 001,011,111 → parity 0 (1+2+3=6 ones), out_z=0. Mode 5 on the same frame → out_z=1.
- Backpressure: hold out_ready=0 for 5 cycles after a result → out_valid, out_z and out_beats stable, in_ready=0 throughout. Release → in_ready=1 on the following cycle.
- Reset asserted during ACCUM after 2 beats → out_valid=0 immediately. The next frame, mode 1 with single beat 000, gives out_z=0, out_beats=1.
- Mode 6 → out_err=1, out_z=0. With GATE_REDUCE_MASK_EN, mode 0, data 011, mask 011 → out_z=1.

Source files
------------

// File: rtl/gate_reduce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_reduce_pkg
// Description : Shared types and helpers for the gate_reduce frame reducer:
//               operation mode encoding, base operation, FSM state encoding
//               and the per-operation identity value.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_reduce_pkg;

    // Operation selector as presented on the mode port
    typedef enum logic [2:0] {
        MODE_AND   = 3'd0,
        MODE_OR    = 3'd1,
        MODE_XOR   = 3'd2,
        MODE_NAND  = 3'd3,
        MODE_NOR   = 3'd4,
        MODE_XNOR  = 3'd5,
        MODE_RSV6  = 3'd6,
        MODE_RSV7  = 3'd7
    } mode_t;

    // Underlying associative operation; inversion is applied once per frame
    typedef enum logic [1:0] {
        OP_AND = 2'd0,
        OP_OR  = 2'd1,
        OP_XOR = 2'd2
    } op_t;

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_ACCUM = 2'd1;
    localparam logic [1:0] C_ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = C_ST_IDLE,
        ACCUM = C_ST_ACCUM,
        DONE  = C_ST_DONE
    } state_t;

    // Value that leaves the operation's result unchanged
    function automatic logic op_identity(input op_t op);
        return (op == OP_AND);
    endfunction

    function automatic op_t mode_base_op(input mode_t m);
        case (m)
            MODE_OR,  MODE_NOR:  return OP_OR;
            MODE_XOR, MODE_XNOR: return OP_XOR;
            default:             return OP_AND;
        endcase
    endfunction

    function automatic logic mode_inverts(input mode_t m);
        return (m == MODE_NAND) || (m == MODE_NOR) || (m == MODE_XNOR);
    endfunction

    function automatic logic mode_reserved(input mode_t m);
        return (m == MODE_RSV6) || (m == MODE_RSV7);
    endfunction

    function automatic logic op_combine(input op_t op, input logic a, input logic b);
        case (op)
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return a & b;
        endcase
    endfunction

endpackage : gate_reduce_pkg
`default_nettype wire

// File: rtl/gate_reduce_beat.sv
`default_nettype none
// ============================================================================
// Module      : gate_reduce_beat
// Description : Combinational reduction of one WIDTH-bit beat to a single bit
//               using the selected base operation (AND/OR/XOR).
//               Optional macro GATE_REDUCE_MASK_EN adds the mask input; masked
//               off bits are replaced by the operation's identity value.
// Ports       : data [WIDTH]  beat payload
//               op            base operation
//               mask [WIDTH]  (GATE_REDUCE_MASK_EN only) 1 = bit participates
//               z             reduced bit
// Revision    : 1.0 - initial release
// ============================================================================
module gate_reduce_beat
    import gate_reduce_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] data,
    input  op_t              op,
`ifdef GATE_REDUCE_MASK_EN
    input  logic [WIDTH-1:0] mask,
`endif
    output logic             z
);

    logic [WIDTH-1:0] w_eff;

`ifdef GATE_REDUCE_MASK_EN
    // An all-zero mask therefore reduces to the identity and leaves the
    // accumulator untouched when combined.
    assign w_eff = (data & mask) | ({WIDTH{op_identity(op)}} & ~mask);
`else
    assign w_eff = data;
`endif

    always_comb begin
        z = 1'b0;
        case (op)
            OP_AND:  z = &w_eff;
            OP_OR:   z = |w_eff;
            OP_XOR:  z = ^w_eff;
            default: z = 1'b0;
        endcase
    end

endmodule : gate_reduce_beat
`default_nettype wire

// File: rtl/gate_reduce.sv
`default_nettype none
// ============================================================================
// Module      : gate_reduce
// Description : Frame-wide logic reduction (AND/OR/XOR/NAND/NOR/XNOR) over a
//               multi-beat valid/ready stream; one registered result per frame.
//               Optional macro GATE_REDUCE_MASK_EN adds the in_mask port.
// Ports       : clk, rst (async, active high)
//               in_valid/in_ready/in_data/in_last/mode  input beat stream
//               in_mask (GATE_REDUCE_MASK_EN only)       per-bit participation
//               out_valid/out_ready                      result handshake
//               out_z, out_beats, out_err                frame result
// Revision    : 1.0 - initial release
// ============================================================================
module gate_reduce
    import gate_reduce_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic [2:0]       mode,
`ifdef GATE_REDUCE_MASK_EN
    input  logic [WIDTH-1:0] in_mask,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_z,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_err
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    state_t           r_state;
    op_t              r_op;
    logic             r_inv;
    logic             r_rsv;
    logic             r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_z;
    logic [CNT_W-1:0] r_beats;
    logic             r_err;

    logic             w_first;
    logic             w_accept;
    mode_t            w_mode;
    op_t              w_op;
    logic             w_inv;
    logic             w_rsv;
    logic             w_beat;
    logic             w_acc_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_z_final;

    assign w_mode   = mode_t'(mode);
    assign w_first  = (r_state == IDLE);
    assign w_accept = in_valid && r_in_ready;

    // The first beat uses the live mode; later beats use the latched copy so
    // mid-frame mode changes have no effect.
    assign w_op  = w_first ? mode_base_op(w_mode)  : r_op;
    assign w_inv = w_first ? mode_inverts(w_mode)  : r_inv;
    assign w_rsv = w_first ? mode_reserved(w_mode) : r_rsv;

    gate_reduce_beat #(
        .WIDTH (WIDTH)
    ) u_beat (
        .data (in_data),
        .op   (w_op),
`ifdef GATE_REDUCE_MASK_EN
        .mask (in_mask),
`endif
        .z    (w_beat)
    );

    assign w_acc_next = w_first ? w_beat : op_combine(r_op, r_acc, w_beat);
    assign w_cnt_next = w_first ? c_cnt_one
                      : ((r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_one);
    // Inversion applies once to the whole frame, never per beat
    assign w_z_final  = w_rsv ? 1'b0 : (w_acc_next ^ w_inv);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op        <= OP_AND;
            r_inv       <= 1'b0;
            r_rsv       <= 1'b0;
            r_acc       <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_z         <= 1'b0;
            r_beats     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_acc_next;
                        r_cnt <= w_cnt_next;
                        if (w_first) begin
                            r_op  <= w_op;
                            r_inv <= w_inv;
                            r_rsv <= w_rsv;
                        end
                        if (in_last) begin
                            r_state     <= DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_z         <= w_z_final;
                            r_beats     <= w_cnt_next;
                            r_err       <= w_rsv;
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_z     = r_z;
    assign out_beats = r_beats;
    assign out_err   = r_err;

endmodule : gate_reduce
`default_nettype wire

// File: tb/tb_gate_reduce.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_reduce
// Description : Self-checking bench for gate_reduce. A frame-level model
//               counts participating ones/zeros per frame and derives the
//               result from the operation rules; every cycle the DUT outputs
//               are compared with it. Directed frames also carry literal
//               expected results. GATE_REDUCE_MASK_EN enables mask tests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_reduce;

    localparam int WIDTH = 3;
    localparam int CNT_W = 8;
    localparam int BEAT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic [2:0]       mode;
    logic [WIDTH-1:0] in_mask;
    logic             out_valid;
    logic             out_ready;
    logic             out_z;
    logic [CNT_W-1:0] out_beats;
    logic             out_err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    gate_reduce #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .mode      (mode),
`ifdef GATE_REDUCE_MASK_EN
        .in_mask   (in_mask),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_beats (out_beats),
        .out_err   (out_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- frame-level model ----------------
    logic       m_done, m_z, m_err, m_in_frame;
    int         m_beats_out, m_n, m_ones, m_zeros;
    logic [2:0] m_mode;
    logic [WIDTH-1:0] m_mask;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_done = 1'b0; m_z = 1'b0; m_err = 1'b0; m_beats_out = 0; m_in_frame = 1'b0;
        end else if (m_done) begin
            if (out_ready) m_done = 1'b0;
        end else if (in_valid) begin
            if (!m_in_frame) begin
                m_mode = mode; m_n = 0; m_ones = 0; m_zeros = 0; m_in_frame = 1'b1;
            end
            m_n++;
`ifdef GATE_REDUCE_MASK_EN
            m_mask = in_mask;
`else
            m_mask = '1;
`endif
            for (int i = 0; i < WIDTH; i++)
                if (m_mask[i]) begin
                    if (in_data[i]) m_ones++;
                    else m_zeros++;
                end
            if (in_last) begin
                m_err = 1'b0;
                case (m_mode)
                    3'd0: m_z = (m_zeros == 0);
                    3'd1: m_z = (m_ones > 0);
                    3'd2: m_z = (m_ones % 2 == 1);
                    3'd3: m_z = (m_zeros != 0);
                    3'd4: m_z = (m_ones == 0);
                    3'd5: m_z = (m_ones % 2 == 0);
                    default: begin m_z = 1'b0; m_err = 1'b1; end
                endcase
                m_beats_out = (m_n > BEAT_MAX) ? BEAT_MAX : m_n;
                m_done = 1'b1;
                m_in_frame = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("model_in_ready",  64'(in_ready),  64'(!m_done));
        chk("model_out_valid", 64'(out_valid), 64'(m_done));
        chk("model_out_z",     64'(out_z),     64'(m_z));
        chk("model_out_beats", 64'(out_beats), 64'(m_beats_out));
        chk("model_out_err",   64'(out_err),   64'(m_err));
    end

    // ---------------- directed stimulus ----------------
    task automatic beat(input logic [2:0] d, input logic [2:0] md, input logic last);
        in_valid = 1'b1; in_data = d; mode = md; in_last = last;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic result(input string name, input logic z, input int beats, input logic err);
        int k = 0;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_valid"}, 64'(out_valid), 64'(1));
        chk({name, "_z"},     64'(out_z),     64'(z));
        chk({name, "_beats"}, 64'(out_beats), 64'(beats));
        chk({name, "_err"},   64'(out_err),   64'(err));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        in_last = 1'b0; mode = 3'd0; in_mask = '1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_z",     64'(out_z),     64'(0));
        chk("rst_out_beats", 64'(out_beats), 64'(0));
        chk("rst_out_err",   64'(out_err),   64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // AND over single-beat frames
        for (int v = 0; v < 8; v++) begin
            beat(3'(v), 3'd0, 1'b1);
            result("and_single", (v == 7), 1, 1'b0);
        end

        // NAND
        beat(3'b111, 3'd3, 1'b0); beat(3'b111, 3'd3, 1'b0); beat(3'b110, 3'd3, 1'b1);
        result("nand_one_zero", 1'b1, 3, 1'b0);
        beat(3'b111, 3'd3, 1'b0); beat(3'b111, 3'd3, 1'b0); beat(3'b111, 3'd3, 1'b1);
        result("nand_all_ones", 1'b0, 3, 1'b0);

        // XOR / XNOR parity: six ones
        beat(3'b001, 3'd2, 1'b0); beat(3'b011, 3'd2, 1'b0); beat(3'b111, 3'd2, 1'b1);
        result("xor_parity", 1'b0, 3, 1'b0);
        beat(3'b001, 3'd5, 1'b0); beat(3'b011, 3'd5, 1'b0); beat(3'b111, 3'd5, 1'b1);
        result("xnor_parity", 1'b1, 3, 1'b0);

        // NOR, and a mode change mid-frame that must be ignored (OR stays)
        beat(3'b000, 3'd4, 1'b0); beat(3'b000, 3'd4, 1'b1);
        result("nor_zeros", 1'b1, 2, 1'b0);
        beat(3'b000, 3'd1, 1'b0); beat(3'b001, 3'd0, 1'b1);
        result("mode_change_ignored", 1'b1, 2, 1'b0);

        // Backpressure
        beat(3'b101, 3'd0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_out_z",     64'(out_z),     64'(0));
            chk("bp_out_beats", 64'(out_beats), 64'(1));
            chk("bp_in_ready",  64'(in_ready),  64'(0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_in_ready",  64'(in_ready),  64'(1));
        chk("bp_release_out_valid", 64'(out_valid), 64'(0));

        // Reset in the middle of a frame
        beat(3'b111, 3'd0, 1'b0); beat(3'b111, 3'd0, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_in_ready",  64'(in_ready),  64'(1));
        chk("midrst_out_beats", 64'(out_beats), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        beat(3'b000, 3'd1, 1'b1);
        result("after_rst_or", 1'b0, 1, 1'b0);

        // Reserved modes
        beat(3'b011, 3'd6, 1'b0); beat(3'b111, 3'd6, 1'b1);
        result("reserved6", 1'b0, 2, 1'b1);
        beat(3'b111, 3'd7, 1'b1);
        result("reserved7", 1'b0, 1, 1'b1);
        beat(3'b111, 3'd0, 1'b1);
        result("err_clears", 1'b1, 1, 1'b0);

        // Counter saturation; reduction must remain correct past it
        for (int i = 0; i < 300; i++) beat(3'b111, 3'd0, (i == 299));
        result("sat_and", 1'b1, BEAT_MAX, 1'b0);
        for (int i = 0; i < 301; i++) beat(3'b001, 3'd2, (i == 300));
        result("sat_xor", 1'b1, BEAT_MAX, 1'b0);

`ifdef GATE_REDUCE_MASK_EN
        in_mask = 3'b011;
        beat(3'b011, 3'd0, 1'b1);
        result("mask_and", 1'b1, 1, 1'b0);
        in_mask = 3'b111; beat(3'b111, 3'd0, 1'b0);
        in_mask = 3'b000; beat(3'b000, 3'd0, 1'b0);
        in_mask = 3'b111; beat(3'b111, 3'd0, 1'b1);
        result("mask_zero_beat", 1'b1, 3, 1'b0);
        in_mask = 3'b000; beat(3'b111, 3'd2, 1'b0);
        in_mask = 3'b100; beat(3'b100, 3'd2, 1'b1);
        result("mask_xor", 1'b1, 2, 1'b0);
        in_mask = '1;
`endif

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_gate_reduce
`default_nettype wire
